// File: rtl/pid_mc_incr.sv
`default_nettype none
// ============================================================================
//  Module      : pid_mc_incr
//  Description : Multi-channel incremental PID controller. One shared
//                datapath is time-multiplexed over CH independent loops:
//                  u(k) = u(k-1) + kp*(e0-e1) + ki*e0 + kd*(e0-2e1+e2)
//                where e = target - y. Per-channel history (e1, e2, u and
//                saturation flags) is held in small register arrays.
//                Output is clamped symmetrically, and integration is
//                suspended while the loop is pushing further into a
//                saturated rail (conditional-integration anti-windup).
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    clr        in   synchronous clear of all channel state (pulse)
//    in_valid   in   sample request
//    in_ready   out  high only while idle; accept = in_valid & in_ready
//    in_ch      in   channel index of the sample (out-of-range is ignored)
//    target     in   signed setpoint
//    y          in   signed measurement
//    kp/ki/kd   in   unsigned gains, sampled with the request
//    out_valid  out  one-cycle pulse, result fields valid
//    out_ch     out  channel of the result
//    uk         out  signed saturated controller output
//    sat_hi     out  result clamped to +max
//    sat_lo     out  result clamped to -max
// ============================================================================
module pid_mc_incr #(
  parameter int DW  = 12,
  parameter int KW  = 4,
  parameter int CH  = 4,
  parameter int OW  = 17,
  parameter int CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CHW-1:0]       in_ch,
  input  logic [DW-1:0]        target,
  input  logic [DW-1:0]        y,
  input  logic [KW-1:0]        kp,
  input  logic [KW-1:0]        ki,
  input  logic [KW-1:0]        kd,
  output logic                 out_valid,
  output logic [CHW-1:0]       out_ch,
  output logic signed [OW-1:0] uk,
  output logic                 sat_hi,
  output logic                 sat_lo
);

  localparam int c_ew  = DW + 1;               // error width
  localparam int c_d1w = DW + 2;               // first difference
  localparam int c_d2w = DW + 3;               // second difference
  localparam int c_pw  = DW + KW + 4;          // common product width
  localparam int c_duw = DW + KW + 6;          // increment width
  localparam int c_sw  = ((OW > c_duw) ? OW : c_duw) + 1;
  localparam logic signed [c_sw-1:0] c_max = c_sw'((2 ** (OW - 1)) - 1);
  localparam logic signed [c_sw-1:0] c_min = -c_max;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIFF = 2'd1,
    S_MUL  = 2'd2,
    S_ACC  = 2'd3
  } state_t;

  state_t r_state, w_next;

  // Per-channel history
  logic signed [c_ew-1:0] r_e1_arr [CH];
  logic signed [c_ew-1:0] r_e2_arr [CH];
  logic signed [OW-1:0]   r_u_arr  [CH];
  logic                   r_shi_arr[CH];
  logic                   r_slo_arr[CH];

  // In-flight sample
  logic [CHW-1:0]         r_ch;
  logic                   r_ch_ok;
  logic [KW-1:0]          r_kp, r_ki, r_kd;
  logic signed [c_ew-1:0] r_e0, r_e1, r_e2;
  logic signed [OW-1:0]   r_u;
  logic                   r_shi, r_slo;
  logic signed [c_d1w-1:0] r_d1;
  logic signed [c_d2w-1:0] r_d2;
  logic signed [c_pw-1:0]  r_pp, r_pi, r_pd;

  logic                    w_accept;
  logic                    w_ch_ok;
  logic signed [c_ew-1:0]  w_e0;
  logic signed [c_d1w-1:0] w_d1;
  logic signed [c_d2w-1:0] w_e0x, w_e1x2, w_e2x, w_d2;
  logic signed [KW:0]      w_kp_s, w_ki_s, w_kd_s;
  logic signed [c_pw-1:0]  w_pp, w_pi, w_pd;
  logic                    w_hold_int;
  logic signed [c_duw-1:0] w_du;
  logic signed [c_sw-1:0]  w_s;
  logic signed [OW-1:0]    w_u_new;
  logic                    w_hi, w_lo;

  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid && in_ready;
  assign w_ch_ok  = (int'(in_ch) < CH);

  // Sign-extend both operands by one bit so the difference cannot overflow.
  assign w_e0 = $signed({target[DW-1], target}) - $signed({y[DW-1], y});

  // Differences use explicitly extended operands to keep every term at the
  // result width (2*e1 is a left shift with one guard bit).
  assign w_d1   = c_d1w'(r_e0) - c_d1w'(r_e1);
  assign w_e0x  = c_d2w'(r_e0);
  assign w_e2x  = c_d2w'(r_e2);
  assign w_e1x2 = {r_e1[c_ew-1], r_e1, 1'b0};
  assign w_d2   = w_e0x - w_e1x2 + w_e2x;

  // Gains are unsigned; a zero MSB makes them safe signed multiplicands.
  assign w_kp_s = {1'b0, r_kp};
  assign w_ki_s = {1'b0, r_ki};
  assign w_kd_s = {1'b0, r_kd};
  assign w_pp   = c_pw'(w_kp_s) * c_pw'(r_d1);
  assign w_pd   = c_pw'(w_kd_s) * c_pw'(r_d2);

  // Stop integrating while the error would drive the output further into the
  // rail it is already clamped against.
  assign w_hold_int = (r_shi && !r_e0[c_ew-1] && (r_e0 != '0)) ||
                      (r_slo &&  r_e0[c_ew-1]);
  assign w_pi = w_hold_int ? '0 : (c_pw'(w_ki_s) * c_pw'(r_e0));

  assign w_du = c_duw'(r_pp) + c_duw'(r_pi) + c_duw'(r_pd);
  assign w_s  = c_sw'(r_u) + c_sw'(w_du);

  always_comb begin
    w_hi    = 1'b0;
    w_lo    = 1'b0;
    w_u_new = w_s[OW-1:0];
    if (w_s > c_max) begin
      w_hi    = 1'b1;
      w_u_new = c_max[OW-1:0];
    end else if (w_s < c_min) begin
      w_lo    = 1'b1;
      w_u_new = c_min[OW-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_DIFF;
      S_DIFF:  w_next = S_MUL;
      S_MUL:   w_next = S_ACC;
      S_ACC:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (clr) w_next = S_IDLE;
  end

  // --------------------------------------------------------------------------
  // Datapath and channel state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        r_e1_arr[i]  <= '0;
        r_e2_arr[i]  <= '0;
        r_u_arr[i]   <= '0;
        r_shi_arr[i] <= 1'b0;
        r_slo_arr[i] <= 1'b0;
      end
      r_ch      <= '0;
      r_ch_ok   <= 1'b0;
      r_kp      <= '0;
      r_ki      <= '0;
      r_kd      <= '0;
      r_e0      <= '0;
      r_e1      <= '0;
      r_e2      <= '0;
      r_u       <= '0;
      r_shi     <= 1'b0;
      r_slo     <= 1'b0;
      r_d1      <= '0;
      r_d2      <= '0;
      r_pp      <= '0;
      r_pi      <= '0;
      r_pd      <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      uk        <= '0;
      sat_hi    <= 1'b0;
      sat_lo    <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < CH; i++) begin
        r_e1_arr[i]  <= '0;
        r_e2_arr[i]  <= '0;
        r_u_arr[i]   <= '0;
        r_shi_arr[i] <= 1'b0;
        r_slo_arr[i] <= 1'b0;
      end
      r_ch_ok   <= 1'b0;
      out_valid <= 1'b0;
      uk        <= '0;
      sat_hi    <= 1'b0;
      sat_lo    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ch    <= in_ch;
            r_ch_ok <= w_ch_ok;
            r_kp    <= kp;
            r_ki    <= ki;
            r_kd    <= kd;
            r_e0    <= w_e0;
            // An out-of-range channel runs through the pipe on zeros and is
            // dropped at write-back.
            r_e1    <= w_ch_ok ? r_e1_arr[in_ch]  : '0;
            r_e2    <= w_ch_ok ? r_e2_arr[in_ch]  : '0;
            r_u     <= w_ch_ok ? r_u_arr[in_ch]   : '0;
            r_shi   <= w_ch_ok ? r_shi_arr[in_ch] : 1'b0;
            r_slo   <= w_ch_ok ? r_slo_arr[in_ch] : 1'b0;
          end
        end
        S_DIFF: begin
          r_d1 <= w_d1;
          r_d2 <= w_d2;
        end
        S_MUL: begin
          r_pp <= w_pp;
          r_pi <= w_pi;
          r_pd <= w_pd;
        end
        S_ACC: begin
          if (r_ch_ok) begin
            r_u_arr[r_ch]   <= w_u_new;
            r_e2_arr[r_ch]  <= r_e1;
            r_e1_arr[r_ch]  <= r_e0;
            r_shi_arr[r_ch] <= w_hi;
            r_slo_arr[r_ch] <= w_lo;
            out_valid       <= 1'b1;
            out_ch          <= r_ch;
            uk              <= w_u_new;
            sat_hi          <= w_hi;
            sat_lo          <= w_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pid_mc_incr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pid_mc_incr
//  Description : Scoreboard bench for pid_mc_incr (DW=12, KW=4, CH=4, OW=17).
//                The driver pushes the hand-computed result of every accepted
//                sample; a monitor pops and compares on each out_valid.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pid_mc_incr;

  logic               clk;
  logic               rst_n;
  logic               clr;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_ch;
  logic [11:0]        target;
  logic [11:0]        y;
  logic [3:0]         kp, ki, kd;
  logic               out_valid;
  logic [1:0]         out_ch;
  logic signed [16:0] uk;
  logic               sat_hi;
  logic               sat_lo;

  typedef struct {
    logic [1:0]         ch;
    logic signed [16:0] u;
    logic               hi;
    logic               lo;
    int                 cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  pid_mc_incr #(.DW(12), .KW(4), .CH(4), .OW(17)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ch    (in_ch),
    .target   (target),
    .y        (y),
    .kp       (kp),
    .ki       (ki),
    .kd       (kd),
    .out_valid(out_valid),
    .out_ch   (out_ch),
    .uk       (uk),
    .sat_hi   (sat_hi),
    .sat_lo   (sat_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got ch=%0d uk=%0d at cyc %0d, required no out_valid",
                 out_ch, uk, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_ch !== e.ch || uk !== e.u || sat_hi !== e.hi || sat_lo !== e.lo ||
            cyc != e.cyc + 3) begin
          n_fail++;
          $display("FAIL result: got ch=%0d uk=%0d hi=%0d lo=%0d cyc=%0d, required ch=%0d uk=%0d hi=%0d lo=%0d cyc=%0d",
                   out_ch, uk, sat_hi, sat_lo, cyc, e.ch, e.u, e.hi, e.lo, e.cyc + 3);
        end
      end
    end
  end

  task automatic check(input string name, input longint got, input longint req);
    n_chk++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Issue one sample; when push is set, queue its expected result.
  task automatic send(input logic [1:0] ch, input int t, input int yv,
                      input int kpv, input int kiv, input int kdv,
                      input int exp_u, input logic hi, input logic lo, input bit push);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: got in_ready=0, required 1");
    end
    in_valid = 1'b1;
    in_ch    = ch;
    target   = t[11:0];
    y        = yv[11:0];
    kp       = kpv[3:0];
    ki       = kiv[3:0];
    kd       = kdv[3:0];
    @(posedge clk);
    #1;
    if (push) begin
      e.ch  = ch;
      e.u   = exp_u[16:0];
      e.hi  = hi;
      e.lo  = lo;
      e.cyc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (5) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   rdy_cnt;
    exp_t e;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_ch = '0;
    target = '0; y = '0; kp = '0; ki = '0; kd = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_uk", uk, 0);
    check("reset_sat", {sat_hi, sat_lo}, 0);

    // 1: proportional only
    send(0, 100, 0, 1, 0, 0, 100, 0, 0, 1); settle();
    send(0, 100, 0, 1, 0, 0, 100, 0, 0, 1); settle();

    // 2: derivative only, after a clear
    pulse_clr();
    check("clr_uk", uk, 0);
    send(0, 100, 0, 0, 0, 1, 100, 0, 0, 1); settle();
    send(0, 100, 0, 0, 0, 1, 0,   0, 0, 1); settle();
    send(0, 100, 0, 0, 0, 1, 0,   0, 0, 1); settle();

    // 3: integral into saturation, then windup blocked
    send(2, 2047, -2048, 0, 15, 0, 61425, 0, 0, 1); settle();
    send(2, 2047, -2048, 0, 15, 0, 65535, 1, 0, 1); settle();
    send(2, 2047, -2048, 0, 15, 0, 65535, 0, 0, 1); settle();

    // 4: channel isolation
    send(1, 10, 0, 0, 1, 0, 10,  0, 0, 1); settle();
    send(3, 0,  5, 0, 1, 0, -5,  0, 0, 1); settle();
    send(1, 10, 0, 0, 1, 0, 20,  0, 0, 1); settle();
    send(3, 0,  5, 0, 1, 0, -10, 0, 0, 1); settle();

    // 6: continuous in_valid on ch1 with zero gains; u stays 20
    @(negedge clk);
    in_valid = 1'b1; in_ch = 2'd1; target = '0; y = '0; kp = '0; ki = '0; kd = '0;
    rdy_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (in_ready) begin
        rdy_cnt++;
        e.ch = 2'd1; e.u = 17'sd20; e.hi = 1'b0; e.lo = 1'b0; e.cyc = cyc + 1;
        sb.push_back(e);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("ready_duty", rdy_cnt, 4);
    settle();

    // 5: clear during MUL aborts the sample and wipes ch0 (u=30 beforehand)
    send(0, 30, 0, 0, 1, 0, 30, 0, 0, 1); settle();
    send(0, 50, 0, 0, 1, 0, 0, 0, 0, 0);   // now in DIFF
    @(negedge clk);                        // now in MUL
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_uk", uk, 0);
    settle();
    send(0, 7, 0, 0, 1, 0, 7, 0, 0, 1); settle();

    // 7: negative saturation on ch0
    send(0, -2048, 2047, 0, 15, 0, -61418, 0, 0, 1); settle();
    send(0, -2048, 2047, 0, 15, 0, -65535, 0, 1, 1); settle();

    settle();
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
